bpu_rx_deframer: RTL and testbench

Receive-side counterpart of the BPU transmit path. Consumes the 64-bit framed word stream produced by the transmit board (header, payload, XOR trailer) and hunts for frame sync. It strips header and trailer and forwards payload words on an AXI4-Stream master toward the XDMA C2H channel. Each frame carries a good/bad flag on its last beat, and the block keeps saturating error/frame counters for host readback.

---
 rtl/bpu_frame_pkg.sv | 22 ++
 rtl/bpu_sat_counter.sv | 34 +++
 rtl/bpu_rx_deframer.sv | 191 +++++++++++++++++++
 tb/tb_bpu_rx_deframer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_frame_pkg.sv
// Shared definitions for the BPU frame format: sync word, header field positions
// and the receive deframer state encoding.
package bpu_frame_pkg;

    localparam logic [31:0] SYNC_WORD_DEF = 32'hEB90_146F;

    localparam int SYNC_HI = 63;
    localparam int SYNC_LO = 32;
    localparam int SEQ_HI  = 31;
    localparam int SEQ_LO  = 16;
    localparam int LEN_HI  = 15;
    localparam int LEN_LO  = 0;

    localparam int LEN_W = 16;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_e;

endpackage

// File: rtl/bpu_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module bpu_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bpu_rx_deframer.sv
// Receive deframer: hunts for the sync header, strips header/trailer, forwards
// payload on AXI4-Stream with a per-frame checksum flag, and keeps error counters.
module bpu_rx_deframer
    import bpu_frame_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter logic [31:0] SYNC_WORD  = SYNC_WORD_DEF,
    parameter int          MAX_LEN    = 256
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  cnt_clr,
    output logic [31:0]           frame_cnt,
    output logic [15:0]           chk_err_cnt,
    output logic [15:0]           len_err_cnt,
    output logic [15:0]           seq_err_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e                  state_q;
    state_e                  state_d;
    logic                    alive_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   csum_q;
    logic [15:0]             last_seq_q;
    logic                    seq_seen_q;
    logic [DATA_WIDTH-1:0]   tdata_q;
    logic                    tvalid_q;
    logic                    tlast_q;
    logic                    tuser_q;
    logic                    held_q;

    logic                    accept;
    logic                    is_sync;
    logic [15:0]             hdr_seq;
    logic [LEN_W-1:0]        hdr_len;
    logic                    len_ok;
    logic                    last_word;
    logic                    hdr_take;
    logic                    pl_take;
    logic                    tr_take;
    logic                    chk_ok;
    logic                    inc_frame;
    logic                    inc_chk;
    logic                    inc_len;
    logic                    inc_seq;

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign is_sync   = (s_axis_tdata[SYNC_HI:SYNC_LO] == SYNC_WORD);
    assign hdr_seq   = s_axis_tdata[SEQ_HI:SEQ_LO];
    assign hdr_len   = s_axis_tdata[LEN_HI:LEN_LO];
    assign len_ok    = (hdr_len != '0) && (hdr_len <= MAX_LEN_L);
    assign last_word = (cnt_q == (len_q - 1'b1));
    assign chk_ok    = (s_axis_tdata == csum_q);

    assign hdr_take  = accept && (state_q == HUNT) && is_sync && len_ok;
    assign pl_take   = accept && (state_q == PAYLOAD);
    assign tr_take   = accept && (state_q == TRAILER);

    assign inc_len   = accept && (state_q == HUNT) && is_sync && !len_ok;
    assign inc_seq   = hdr_take && seq_seen_q && (hdr_seq != (last_seq_q + 16'd1));
    assign inc_frame = tr_take && chk_ok;
    assign inc_chk   = tr_take && !chk_ok;

    // FSM: state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (hdr_take) state_d = PAYLOAD;
            PAYLOAD: if (pl_take && last_word) state_d = TRAILER;
            TRAILER: if (tr_take) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // FSM: outputs; input is held off until the first clock after reset release
    always_comb begin
        s_axis_tready = 1'b0;
        if (alive_q) begin
            case (state_q)
                HUNT:    s_axis_tready = 1'b1;
                PAYLOAD: s_axis_tready = !held_q && (!tvalid_q || m_axis_tready);
                TRAILER: s_axis_tready = 1'b1;
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            alive_q    <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            last_seq_q <= '0;
            seq_seen_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (hdr_take) begin
                len_q      <= hdr_len;
                csum_q     <= s_axis_tdata;
                cnt_q      <= '0;
                last_seq_q <= hdr_seq;
                seq_seen_q <= 1'b1;
            end
            if (pl_take) begin
                csum_q  <= csum_q ^ s_axis_tdata;
                cnt_q   <= cnt_q + 1'b1;
                tdata_q <= s_axis_tdata;
                tlast_q <= 1'b0;
                tuser_q <= 1'b0;
                // The final word waits in the slot until its trailer verdict arrives
                if (last_word) begin
                    tvalid_q <= 1'b0;
                    held_q   <= 1'b1;
                end else begin
                    tvalid_q <= 1'b1;
                end
            end else if (tr_take) begin
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b1;
                tuser_q  <= !chk_ok;
                held_q   <= 1'b0;
            end else if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

    bpu_sat_counter #(.WIDTH(32)) u_frame_cnt (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (inc_frame),
        .count_o (frame_cnt)
    );

    bpu_sat_counter #(.WIDTH(16)) u_chk_err_cnt (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (inc_chk),
        .count_o (chk_err_cnt)
    );

    bpu_sat_counter #(.WIDTH(16)) u_len_err_cnt (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (inc_len),
        .count_o (len_err_cnt)
    );

    bpu_sat_counter #(.WIDTH(16)) u_seq_err_cnt (
        .clk_i   (sys_clk),
        .rst_ni  (sys_rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (inc_seq),
        .count_o (seq_err_cnt)
    );

endmodule

// File: tb/tb_bpu_rx_deframer.sv
// Self-checking bench for bpu_rx_deframer: frame-level model plus directed tests.
module tb_bpu_rx_deframer;

    localparam logic [31:0] SYNC = 32'hEB90_146F;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        cnt_clr = 1'b0;
    logic [31:0] frame_cnt;
    logic [15:0] chk_err_cnt;
    logic [15:0] len_err_cnt;
    logic [15:0] seq_err_cnt;

    bpu_rx_deframer dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .cnt_clr       (cnt_clr),
        .frame_cnt     (frame_cnt),
        .chk_err_cnt   (chk_err_cnt),
        .len_err_cnt   (len_err_cnt),
        .seq_err_cnt   (seq_err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic        u;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       got_q[$];
    int          m_frame = 0;
    int          m_chk = 0;
    int          m_len = 0;
    int          m_seq = 0;
    bit          m_seq_seen = 1'b0;
    logic [15:0] m_last_seq = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          in_pl = 1'b0;
    bit          rdy_mode = 1'b0;
    int          rdy_idx = 0;
    logic        rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    function automatic int sat_inc(int v, int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    // Output readiness: always ready, or a repeating 1-0-0-1 stall pattern
    always @(posedge sys_clk) begin
        #1;
        if (rdy_mode) begin
            m_axis_tready = rdy_pat[rdy_idx % 4];
            rdy_idx++;
        end else begin
            m_axis_tready = 1'b1;
        end
    end

    // Compare process: every output handshake against the model queue
    logic        stall_prev = 1'b0;
    logic [63:0] prev_d;
    logic        prev_l;
    logic        prev_u;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {63'd0, m_axis_tvalid}, 64'd1);
                check("stall_data", m_axis_tdata, prev_d);
                check("stall_last", {63'd0, m_axis_tlast}, {63'd0, prev_l});
                check("stall_user", {63'd0, m_axis_tuser}, {63'd0, prev_u});
            end
            if (in_pl && m_axis_tvalid && !m_axis_tready)
                check("stall_s_ready", {63'd0, s_axis_tready}, 64'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", m_axis_tdata, 64'hFFFF_FFFF_FFFF_FFFF ^ m_axis_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.d);
                    check("beat_last", {63'd0, m_axis_tlast}, {63'd0, e.l});
                    check("beat_user", {63'd0, m_axis_tuser}, {63'd0, e.u});
                end
                got_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser});
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            prev_u = m_axis_tuser;
        end
    end

    task automatic send_word(input logic [63:0] w, input bit clr);
        int t;
        t = 0;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        cnt_clr       = clr;
        @(negedge sys_clk);
        while (!s_axis_tready && t < 200) begin
            t++;
            @(negedge sys_clk);
        end
        if (!s_axis_tready) begin
            check("s_ready_timeout", {63'd0, s_axis_tready}, 64'd1);
        end
        @(posedge sys_clk);
        #1;
        s_axis_tvalid = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    task automatic send_bad_hdr(input logic [15:0] seq, input logic [15:0] len);
        send_word({SYNC, seq, len}, 1'b0);
        m_len = sat_inc(m_len, 65535);
    endtask

    // Frame-level model: expected beats follow directly from the frame contents
    task automatic send_frame(input logic [15:0] seq, input int len, input logic [63:0] base,
                              input logic [63:0] step, input bit corrupt, input bit clr,
                              input int abort_after);
        logic [63:0] hdr;
        logic [63:0] x;
        logic [63:0] w;
        logic [63:0] trl;
        hdr = {SYNC, seq, 16'(len)};
        if (m_seq_seen && seq != (m_last_seq + 16'd1)) m_seq = sat_inc(m_seq, 65535);
        m_last_seq = seq;
        m_seq_seen = 1'b1;
        send_word(hdr, 1'b0);
        in_pl = 1'b1;
        x = hdr;
        trl = '0;
        for (int i = 0; i < len; i++) begin
            if (abort_after > 0 && i == abort_after) begin
                in_pl = 1'b0;
                return;
            end
            w = base + step * 64'(i);
            x = x ^ w;
            if (i == len - 1) begin
                trl = corrupt ? (x ^ 64'd1) : x;
                exp_q.push_back('{w, 1'b1, (trl != x)});
            end else begin
                exp_q.push_back('{w, 1'b0, 1'b0});
            end
            send_word(w, 1'b0);
        end
        in_pl = 1'b0;
        send_word(trl, clr);
        if (clr) begin
            m_frame = 0; m_chk = 0; m_len = 0; m_seq = 0;
        end else if (trl != x) begin
            m_chk = sat_inc(m_chk, 65535);
        end else begin
            m_frame = sat_inc(m_frame, 32'h7FFF_FFFF);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            t++;
            @(negedge sys_clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic check_counters(string tag);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frame));
        check({tag, "_chk_err_cnt"}, 64'(chk_err_cnt), 64'(m_chk));
        check({tag, "_len_err_cnt"}, 64'(len_err_cnt), 64'(m_len));
        check({tag, "_seq_err_cnt"}, 64'(seq_err_cnt), 64'(m_seq));
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #2;
        check("rst_m_valid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_m_data", m_axis_tdata, 64'd0);
        check("rst_m_last_user", {62'd0, m_axis_tlast, m_axis_tuser}, 64'd0);
        check("rst_s_ready", {63'd0, s_axis_tready}, 64'd0);
        check("rst_counters", {frame_cnt, chk_err_cnt | len_err_cnt | seq_err_cnt, 16'd0}, 64'd0);
        exp_q.delete();
        got_q.delete();
        m_frame = 0; m_chk = 0; m_len = 0; m_seq = 0;
        m_seq_seen = 1'b0;
        m_last_seq = '0;
        in_pl = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        // Test 1: single good frame
        do_reset();
        send_frame(16'd5, 3, 64'h11, 64'h11, 1'b0, 1'b0, 0);
        wait_drain();
        $display("test1 good frame: %0d beats, frame_cnt=%0d", got_q.size(), frame_cnt);
        check("t1_beats", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            check("t1_d0", got_q[0].d, 64'h11);
            check("t1_d1", got_q[1].d, 64'h22);
            check("t1_d2", got_q[2].d, 64'h33);
            check("t1_last", {62'd0, got_q[1].l, got_q[2].l}, 64'd1);
            check("t1_user", {63'd0, got_q[2].u}, 64'd0);
        end
        check("t1_frame_lit", 64'(frame_cnt), 64'd1);
        check("t1_err_lit", {16'd0, chk_err_cnt, len_err_cnt, seq_err_cnt}, 64'd0);
        check_counters("t1");

        // Test 2: corrupt trailer
        do_reset();
        send_frame(16'd6, 2, 64'hA0, 64'd1, 1'b1, 1'b0, 0);
        wait_drain();
        $display("test2 corrupt trailer: %0d beats, chk_err_cnt=%0d", got_q.size(), chk_err_cnt);
        check("t2_beats", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) check("t2_last_user", {62'd0, got_q[1].l, got_q[1].u}, 64'd3);
        check("t2_chk_lit", 64'(chk_err_cnt), 64'd1);
        check("t2_frame_lit", 64'(frame_cnt), 64'd0);
        check_counters("t2");

        // Test 3: garbage, bad lengths, then a len=1 frame
        do_reset();
        send_word(64'hDEAD_BEEF_0000_0001, 1'b0);
        send_word(64'hDEAD_BEEF_1234_5678, 1'b0);
        send_bad_hdr(16'd9, 16'd0);
        send_bad_hdr(16'd10, 16'd257);
        send_frame(16'h20, 1, 64'h5555, 64'd1, 1'b0, 1'b0, 0);
        wait_drain();
        $display("test3 hunt: %0d beats, len_err_cnt=%0d", got_q.size(), len_err_cnt);
        check("t3_beats", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            check("t3_d0", got_q[0].d, 64'h5555);
            check("t3_last", {63'd0, got_q[0].l}, 64'd1);
        end
        check("t3_len_lit", 64'(len_err_cnt), 64'd2);
        check_counters("t3");

        // Test 4: sequence wrap
        do_reset();
        send_frame(16'hFFFE, 2, 64'h1000, 64'd1, 1'b0, 1'b0, 0);
        send_frame(16'hFFFF, 2, 64'h2000, 64'd1, 1'b0, 1'b0, 0);
        send_frame(16'h0000, 2, 64'h3000, 64'd1, 1'b0, 1'b0, 0);
        send_frame(16'h0002, 2, 64'h4000, 64'd1, 1'b0, 1'b0, 0);
        wait_drain();
        $display("test4 seq wrap: %0d beats, seq_err_cnt=%0d", got_q.size(), seq_err_cnt);
        check("t4_beats", 64'(got_q.size()), 64'd8);
        check("t4_seq_lit", 64'(seq_err_cnt), 64'd1);
        check("t4_frame_lit", 64'(frame_cnt), 64'd4);
        check_counters("t4");

        // Test 5: stalled output, back-to-back frames, sync-like payload
        do_reset();
        rdy_mode = 1'b1;
        rdy_idx = 0;
        send_frame(16'd1, 4, 64'h100, 64'd1, 1'b0, 1'b0, 0);
        send_frame(16'd2, 4, {SYNC, 32'h0000_0004}, 64'd1, 1'b0, 1'b0, 0);
        wait_drain();
        rdy_mode = 1'b0;
        $display("test5 backpressure: %0d beats, frame_cnt=%0d", got_q.size(), frame_cnt);
        check("t5_beats", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            check("t5_d0", got_q[0].d, 64'h100);
            check("t5_d4", got_q[4].d, {SYNC, 32'h0000_0004});
            check("t5_lasts", {62'd0, got_q[3].l, got_q[7].l}, 64'd3);
        end
        check("t5_frame_lit", 64'(frame_cnt), 64'd2);
        check_counters("t5");

        // Test 6: reset mid-frame, then a clean frame
        do_reset();
        send_frame(16'd3, 6, 64'h600, 64'd1, 1'b0, 1'b0, 2);
        wait_drain();
        do_reset();
        send_frame(16'd4, 2, 64'h700, 64'd1, 1'b0, 1'b0, 0);
        wait_drain();
        $display("test6 mid-frame reset: %0d beats, frame_cnt=%0d", got_q.size(), frame_cnt);
        check("t6_beats", 64'(got_q.size()), 64'd2);
        check("t6_frame_lit", 64'(frame_cnt), 64'd1);
        check_counters("t6");

        // Test 7: clear in the same cycle as a good trailer
        do_reset();
        send_frame(16'd8, 2, 64'h800, 64'd1, 1'b0, 1'b1, 0);
        wait_drain();
        $display("test7 clear vs increment: %0d beats, frame_cnt=%0d", got_q.size(), frame_cnt);
        check("t7_beats", 64'(got_q.size()), 64'd2);
        check("t7_frame_lit", 64'(frame_cnt), 64'd0);
        check_counters("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
